// File: rtl/usb_out_pkg.sv
// Shared definitions for the USB output arbiter: FSM state codes, channel
// indices and a small one-hot helper.
package usb_out_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_LOAD       = 3'd1;
  localparam state_t ST_SEND_LO    = 3'd2;
  localparam state_t ST_SEND_HI    = 3'd3;
  localparam state_t ST_FLUSH_ARM  = 3'd4;
  localparam state_t ST_FLUSH_WAIT = 3'd5;

  localparam logic CH_DATA = 1'b0;
  localparam logic CH_STAT = 1'b1;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/usb_out_arbiter_rr_arb2.sv
// Two-requester round-robin picker. Remembers the last owner; the pick is
// combinational and the owner memory only moves on the update strobe.
module rr_arb2
  import usb_out_pkg::*;
(
  input  logic       ifclk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_owner,
  output logic       o_any,
  output logic       o_pick
);

  logic r_last_owner;

  always_ff @(posedge ifclk) begin
    if (reset) begin
      r_last_owner <= CH_STAT;
    end else if (i_update) begin
      r_last_owner <= i_owner;
    end
  end

  // With both requesting, the channel that did not go last wins.
  assign o_any  = |i_req;
  assign o_pick = (&i_req) ? ~r_last_owner : i_req[1];

endmodule

// File: rtl/usb_out_arbiter.sv
// Shares the 16-bit EZ-USB output path between two 32-bit word streams with
// packet-granular round-robin, a burst limit and manual PKTEND sequencing.
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | no owner; pick a requester when enabled
// LOAD        | owner granted, waiting for / taking its next word
// SEND_LO     | presenting wbuf[15:0] to DI
// SEND_HI     | presenting wbuf[31:16]; chains the next word if possible
// FLUSH_ARM   | packet done, raise pktend_arm
// FLUSH_WAIT  | hold pktend_arm until PKTEND seen low or timeout
module usb_out_arbiter
  import usb_out_pkg::*;
#(
  parameter int MAX_BURST      = 256,
  parameter int PKTEND_TIMEOUT = 1024
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] ch0_data,
  input  logic        ch0_valid,
  input  logic        ch0_last,
  output logic        ch0_ready,
  input  logic [31:0] ch1_data,
  input  logic        ch1_valid,
  input  logic        ch1_last,
  output logic        ch1_ready,
  output logic [15:0] usb_di,
  output logic        usb_di_valid,
  input  logic        usb_di_ready,
  output logic        pktend_arm,
  input  logic        pktend_n,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        pktend_to
);

  localparam int TW = (PKTEND_TIMEOUT > 2) ? $clog2(PKTEND_TIMEOUT) : 1;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;
  logic [1:0]    r_grant;
  logic [31:0]   r_wbuf;
  logic          r_lbuf;
  logic [15:0]   r_burst;
  logic [TW-1:0] r_to_cnt;
  logic          r_busy;
  logic          r_pktend_to;

  logic          w_any;
  logic          w_pick;
  logic          w_own_valid;
  logic [31:0]   w_own_data;
  logic          w_own_last;
  logic          w_xfer;
  logic          w_at_limit;
  logic          w_grant_now;
  logic          w_load;
  logic          w_ack;
  logic          w_to_hit;
  logic          w_release;

  rr_arb2 u_rr (
    .ifclk    (ifclk),
    .reset    (reset),
    .i_req    ({ch1_valid, ch0_valid}),
    .i_update (w_release),
    .i_owner  (r_owner),
    .o_any    (w_any),
    .o_pick   (w_pick)
  );

  assign w_own_valid = (r_owner == CH_DATA) ? ch0_valid : ch1_valid;
  assign w_own_data  = (r_owner == CH_DATA) ? ch0_data  : ch1_data;
  assign w_own_last  = (r_owner == CH_DATA) ? ch0_last  : ch1_last;

  assign w_xfer      = usb_di_valid && usb_di_ready;
  assign w_at_limit  = (r_burst == 16'(MAX_BURST));
  assign w_grant_now = (r_state == ST_IDLE) && enable && w_any;
  assign w_ack       = !pktend_n;
  assign w_to_hit    = (r_to_cnt == '0);

  // A chained load in SEND_HI removes the bubble so a word costs two cycles.
  assign w_load = ((r_state == ST_LOAD) && w_own_valid) ||
                  ((r_state == ST_SEND_HI) && w_xfer && !r_lbuf && !w_at_limit &&
                   enable && w_own_valid);

  assign w_release = ((r_state == ST_SEND_HI) && w_xfer && !r_lbuf && (w_at_limit || !enable)) ||
                     ((r_state == ST_FLUSH_WAIT) && (w_ack || w_to_hit));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (w_grant_now) w_next = ST_LOAD;
      ST_LOAD:       if (w_own_valid) w_next = ST_SEND_LO;
      ST_SEND_LO:    if (w_xfer) w_next = ST_SEND_HI;
      ST_SEND_HI: begin
        if (w_xfer) begin
          if (r_lbuf)                      w_next = ST_FLUSH_ARM;
          else if (w_at_limit || !enable)  w_next = ST_IDLE;
          else if (w_own_valid)            w_next = ST_SEND_LO;
          else                             w_next = ST_LOAD;
        end
      end
      ST_FLUSH_ARM:  w_next = ST_FLUSH_WAIT;
      ST_FLUSH_WAIT: if (w_ack || w_to_hit) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= CH_DATA;
      r_grant     <= '0;
      r_wbuf      <= '0;
      r_lbuf      <= 1'b0;
      r_burst     <= '0;
      r_to_cnt    <= '0;
      r_busy      <= 1'b0;
      r_pktend_to <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);

      if (w_grant_now) begin
        r_owner <= w_pick;
        r_grant <= ch_onehot(w_pick);
        r_burst <= '0;
      end else if (w_next == ST_IDLE) begin
        r_grant <= '0;
      end

      if (w_load) begin
        r_wbuf  <= w_own_data;
        r_lbuf  <= w_own_last;
        r_burst <= r_burst + 16'd1;
      end

      // Loaded so that FLUSH_ARM plus the wait cycles total PKTEND_TIMEOUT.
      if (r_state == ST_FLUSH_ARM) begin
        r_to_cnt <= TW'(PKTEND_TIMEOUT - 2);
      end else if ((r_state == ST_FLUSH_WAIT) && !w_to_hit) begin
        r_to_cnt <= r_to_cnt - TW'(1);
      end

      if ((r_state == ST_FLUSH_WAIT) && !w_ack && w_to_hit) begin
        r_pktend_to <= 1'b1;
      end
    end
  end

  always_comb begin
    usb_di = '0;
    case (r_state)
      ST_SEND_LO: usb_di = r_wbuf[15:0];
      ST_SEND_HI: usb_di = r_wbuf[31:16];
      default:    usb_di = '0;
    endcase
  end

  assign usb_di_valid = (r_state == ST_SEND_LO) || (r_state == ST_SEND_HI);
  assign pktend_arm   = (r_state == ST_FLUSH_ARM) || (r_state == ST_FLUSH_WAIT);
  assign ch0_ready    = w_load && (r_owner == CH_DATA);
  assign ch1_ready    = w_load && (r_owner == CH_STAT);
  assign grant        = r_grant;
  assign busy         = r_busy;
  assign pktend_to    = r_pktend_to;

endmodule

// File: tb/tb_usb_out_arbiter.sv
// Directed and randomized checks of usb_out_arbiter against a word/half-word
// scoreboard and per-scenario expected grant orders.
module tb_usb_out_arbiter;

  logic        ifclk, reset, enable;
  logic [31:0] ch0_data, ch1_data;
  logic        ch0_valid, ch0_last, ch0_ready;
  logic        ch1_valid, ch1_last, ch1_ready;
  logic [15:0] usb_di;
  logic        usb_di_valid, usb_di_ready, pktend_arm, pktend_n;
  logic [1:0]  grant;
  logic        busy, pktend_to;

  usb_out_arbiter #(.MAX_BURST(4), .PKTEND_TIMEOUT(16)) dut (
    .ifclk(ifclk), .reset(reset), .enable(enable),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_last(ch0_last), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_last(ch1_last), .ch1_ready(ch1_ready),
    .usb_di(usb_di), .usb_di_valid(usb_di_valid), .usb_di_ready(usb_di_ready),
    .pktend_arm(pktend_arm), .pktend_n(pktend_n),
    .grant(grant), .busy(busy), .pktend_to(pktend_to)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [15:0] exp_h[$];
  int          own_log[$];
  logic [1:0]  gr_log[$];
  logic        ch0_hold   = 1'b0;
  logic        rnd_ready  = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_di    = '0;
  logic        s_valid, s_arm, s_busy, s_rdy0, s_rdy1, s_to;
  logic [15:0] s_di;
  logic [1:0]  s_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic drive();
    ch0_valid    = (q0.size() > 0) && !ch0_hold;
    ch0_data     = (q0.size() > 0) ? q0[0][31:0] : 32'h0;
    ch0_last     = (q0.size() > 0) ? q0[0][32] : 1'b0;
    ch1_valid    = (q1.size() > 0);
    ch1_data     = (q1.size() > 0) ? q1[0][31:0] : 32'h0;
    ch1_last     = (q1.size() > 0) ? q1[0][32] : 1'b0;
    usb_di_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Samples mid-cycle, after inputs settled and before the next rising edge.
  task automatic sample();
    logic [32:0] w;
    #1;
    s_valid = usb_di_valid; s_di = usb_di; s_arm = pktend_arm; s_busy = busy;
    s_grant = grant; s_rdy0 = ch0_ready; s_rdy1 = ch1_ready; s_to = pktend_to;
    if (!reset) begin
      chk("rdy0_legal", 32'(ch0_ready && !(ch0_valid && grant[0])), 32'd0);
      chk("rdy1_legal", 32'(ch1_ready && !(ch1_valid && grant[1])), 32'd0);
      if (prev_stall) begin
        chk("stall_valid", 32'(usb_di_valid), 32'd1);
        chk("stall_data", 32'(usb_di), 32'(prev_di));
      end
      if (ch0_valid && ch0_ready) begin
        w = q0.pop_front();
        exp_h.push_back(w[15:0]); exp_h.push_back(w[31:16]);
        own_log.push_back(0); gr_log.push_back(grant);
      end
      if (ch1_valid && ch1_ready) begin
        w = q1.pop_front();
        exp_h.push_back(w[15:0]); exp_h.push_back(w[31:16]);
        own_log.push_back(1); gr_log.push_back(grant);
      end
      if (usb_di_valid && usb_di_ready) begin
        n_xfer++;
        if (exp_h.size() == 0) chk("xfer_extra", 32'(usb_di), 32'hFFFF_FFFF);
        else chk("xfer_data", 32'(usb_di), 32'(exp_h.pop_front()));
      end
      prev_stall = usb_di_valid && !usb_di_ready;
      prev_di    = usb_di;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic cycle();
    drive();
    sample();
    @(posedge ifclk);
    #1;
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); exp_h.delete(); own_log.delete(); gr_log.delete();
    prev_stall = 1'b0; ch0_hold = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    cycle();
    while (s_busy && n < 200) begin cycle(); n++; end
    chk(tag, 32'(s_busy), 32'd0);
  endtask

  logic        tr_v[20];
  logic [15:0] tr_d[20];
  logic        tr_a[20];
  logic [15:0] e1[6] = '{16'h2222, 16'h1111, 16'h4444, 16'h3333, 16'h6666, 16'h5555};
  int          e5[8] = '{0, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    int n, arm_cycle, arm_cnt, base;
    logic seen;
    reset = 1'b1; enable = 1'b1; pktend_n = 1'b1;
    ch0_data = '0; ch0_valid = 1'b0; ch0_last = 1'b0;
    ch1_data = '0; ch1_valid = 1'b0; ch1_last = 1'b0; usb_di_ready = 1'b1;
    @(posedge ifclk); #1;

    do_reset(3);
    cycle();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_di", 32'(s_di), 32'd0);
    chk("rst_grant", 32'(s_grant), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_arm", 32'(s_arm), 32'd0);
    chk("rst_to", 32'(s_to), 32'd0);

    // Three-word ch0 packet at full rate, PKTEND acknowledged 5 cycles after arm.
    q0.push_back({1'b0, 32'h1111_2222});
    q0.push_back({1'b0, 32'h3333_4444});
    q0.push_back({1'b1, 32'h5555_6666});
    arm_cycle = -1;
    for (int c = 0; c < 20; c++) begin
      if (arm_cycle >= 0 && c == arm_cycle + 5) pktend_n = 1'b0;
      cycle();
      tr_v[c] = s_valid; tr_d[c] = s_di; tr_a[c] = s_arm;
      if (s_arm && arm_cycle < 0) arm_cycle = c;
    end
    pktend_n = 1'b1;
    chk("t1_latency", 32'(tr_v[1]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("t1_valid", 32'(tr_v[2 + k]), 32'd1);
      chk("t1_di", 32'(tr_d[2 + k]), 32'(e1[k]));
    end
    chk("t1_arm_rise", 32'(tr_v[8] == 1'b0 && tr_a[8] == 1'b1), 32'd1);
    for (int k = 9; k < 14; k++) chk("t1_arm_held", 32'(tr_a[k]), 32'd1);
    chk("t1_arm_drop", 32'(tr_a[14]), 32'd0);
    chk("t1_idle", 32'(s_busy), 32'd0);
    chk("t1_drained", 32'(q0.size() + exp_h.size()), 32'd0);

    // Both channels saturated, no last: owners alternate every MAX_BURST=4 words.
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      q0.push_back({1'b0, 32'hA000_0000 | 32'(i)});
      q1.push_back({1'b0, 32'hB000_0000 | 32'(i)});
    end
    n = 0; arm_cnt = 0;
    while (own_log.size() < 24 && n < 300) begin
      cycle(); n++;
      if (s_arm) arm_cnt++;
    end
    chk("t2_budget", 32'(own_log.size() >= 24), 32'd1);
    for (int k = 0; k < 24 && k < own_log.size(); k++) begin
      chk("t2_owner", 32'(own_log[k]), 32'((k / 4) % 2));
      chk("t2_grant", 32'(gr_log[k]), (((k / 4) % 2) != 0) ? 32'd2 : 32'd1);
    end
    chk("t2_no_arm", 32'(arm_cnt), 32'd0);
    enable = 1'b0;
    wait_idle("t2_disable_idle");
    base = own_log.size();
    repeat (5) cycle();
    chk("t2_no_new_load", 32'(own_log.size()), 32'(base));
    chk("t2_word_completed", 32'(exp_h.size()), 32'd0);
    do_reset(2);
    enable = 1'b1;

    // 16-word packet with random DI_ready: order, completeness and hold-stability.
    pktend_n = 1'b0;
    rnd_ready = 1'b1;
    base = n_xfer;
    for (int i = 0; i < 16; i++) q0.push_back({(i == 15), $urandom()});
    n = 0;
    while (n_xfer - base < 32 && n < 500) begin cycle(); n++; end
    rnd_ready = 1'b0;
    chk("t3_xfer_count", 32'(n_xfer - base), 32'd32);
    wait_idle("t3_idle");
    chk("t3_no_extra", 32'(n_xfer - base), 32'd32);
    chk("t3_drained", 32'(exp_h.size()), 32'd0);

    // PKTEND never acknowledged: arm lasts PKTEND_TIMEOUT=16 cycles, flag sticks.
    pktend_n = 1'b1;
    chk("t4_to_clear", 32'(s_to), 32'd0);
    q0.push_back({1'b1, 32'hDEAD_BEEF});
    n = 0; arm_cnt = 0; seen = 1'b0;
    while (n < 100) begin
      cycle(); n++;
      if (s_arm) begin seen = 1'b1; arm_cnt++; end
      else if (seen) break;
    end
    chk("t4_arm_cycles", 32'(arm_cnt), 32'd16);
    chk("t4_to_flag", 32'(s_to), 32'd1);
    chk("t4_idle", 32'(s_busy), 32'd0);
    own_log.delete(); gr_log.delete();
    q1.push_back({1'b1, 32'h5157_A7A5});
    n = 0;
    while (own_log.size() == 0 && n < 20) begin cycle(); n++; end
    chk("t4_next_served", 32'(own_log.size()), 32'd1);
    if (own_log.size() > 0) chk("t4_next_grant", 32'(gr_log[0]), 32'd2);
    pktend_n = 1'b0;
    wait_idle("t4_idle2");
    chk("t4_to_sticky", 32'(s_to), 32'd1);

    // ch0 starves for 10 cycles mid-packet while ch1 waits: no preemption.
    do_reset(2);
    for (int i = 0; i < 6; i++) q0.push_back({(i == 5), 32'hC000_0000 | 32'(i)});
    q1.push_back({1'b0, 32'hD000_0000});
    q1.push_back({1'b1, 32'hD000_0001});
    n = 0;
    while (own_log.size() < 2 && n < 20) begin cycle(); n++; end
    ch0_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t5_grant_held", 32'(s_grant), 32'd1);
      chk("t5_ch1_blocked", 32'(s_rdy1), 32'd0);
    end
    ch0_hold = 1'b0;
    cycle();
    chk("t5_resume", 32'(s_rdy0), 32'd1);
    n = 0;
    while (own_log.size() < 8 && n < 100) begin cycle(); n++; end
    chk("t5_count", 32'(own_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < own_log.size(); k++) chk("t5_order", 32'(own_log[k]), 32'(e5[k]));
    wait_idle("t5_idle");

    // Reset while ch1 sits in SEND_HI; afterwards ch0 must win again.
    q1.push_back({1'b1, 32'hC0DE_F00D});
    base = n_xfer; n = 0;
    while (n_xfer == base && n < 20) begin cycle(); n++; end
    reset = 1'b1;
    cycle();
    chk("t6_in_send_hi", 32'(s_di), 32'h0000_C0DE);
    reset = 1'b0;
    clear_model();
    cycle();
    chk("t6_valid", 32'(s_valid), 32'd0);
    chk("t6_grant", 32'(s_grant), 32'd0);
    chk("t6_arm", 32'(s_arm), 32'd0);
    chk("t6_to", 32'(s_to), 32'd0);
    q0.push_back({1'b1, 32'h0000_0A0A});
    q1.push_back({1'b1, 32'h0000_0B0B});
    n = 0;
    while (own_log.size() == 0 && n < 20) begin cycle(); n++; end
    chk("t6_served", 32'(own_log.size()), 32'd1);
    if (own_log.size() > 0) begin
      chk("t6_first_owner", 32'(own_log[0]), 32'd0);
      chk("t6_first_grant", 32'(gr_log[0]), 32'd1);
    end
    n = 0;
    while (own_log.size() < 2 && n < 40) begin cycle(); n++; end
    wait_idle("t6_idle");
    chk("t6_drained", 32'(exp_h.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
